cached_memory: RTL and testbench

- Memory subsystem: a direct-mapped, write-back, write-allocate cache in front of an internal fixed-latency word RAM model.
- Presents a single-word request/ready port to a processor or testbench.
- Cache and RAM are both inside this block. Only the processor-side port is external.

---
 rtl/cached_memory_if.sv | 15 +
 rtl/cached_memory.sv | 159 +++++++++++++++
 tb/tb_cached_memory.sv | 96 +++++++++
 3 files changed

// File: rtl/cached_memory_if.sv
// Processor-side request/ready port of the cached memory subsystem.
interface cached_memory_if #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned WORD_WIDTH = 64
);
   logic [ADDR_WIDTH-1:0] addr;
   logic [WORD_WIDTH-1:0] din;
   logic [WORD_WIDTH-1:0] dout;
   logic                  re;
   logic                  we;
   logic                  ready;

   modport master (output addr, din, re, we, input dout, ready);
   modport slave  (input addr, din, re, we, output dout, ready);
endinterface

// File: rtl/cached_memory.sv
// Direct-mapped write-back/write-allocate cache over an internal fixed-latency word RAM.
// Misses write back a dirty victim, fill the line, then re-run the lookup as a hit.
module cached_memory #(
   parameter int unsigned ADDR_WIDTH  = 64,
   parameter int unsigned WORD_WIDTH  = 64,
   parameter int unsigned LINE_SIZE   = 2,
   parameter int unsigned LINE_COUNT  = 128,
   parameter int unsigned RAM_LATENCY = 25,
   parameter int unsigned RAM_WORDS   = 1024
) (
   input logic           clk,
   input logic           rst,
   cached_memory_if.slave bus
);
   localparam int unsigned OFF_W  = $clog2(LINE_SIZE);
   localparam int unsigned IDX_W  = $clog2(LINE_COUNT);
   localparam int unsigned TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
   localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
   localparam int unsigned CNT_W  = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOOKUP = 2'd1;
   localparam logic [1:0] S_WB     = 2'd2;
   localparam logic [1:0] S_FILL   = 2'd3;

   logic [1:0]            r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
   logic [WORD_WIDTH-1:0] r_din, w_din_nxt;
   logic                  r_wr, w_wr_nxt;
   logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
   logic [OFF_W-1:0]      r_word, w_word_nxt;
   logic                  r_ready, w_ready_nxt;
   logic [WORD_WIDTH-1:0] r_dout, w_dout_nxt;
   logic [LINE_COUNT-1:0] r_valid, r_dirty;

   logic [TAG_W-1:0]      r_tag  [LINE_COUNT];
   logic [WORD_WIDTH-1:0] r_data [LINE_COUNT*LINE_SIZE];
   logic [WORD_WIDTH-1:0] r_ram  [RAM_WORDS];

   logic [OFF_W-1:0]       w_off;
   logic [IDX_W-1:0]       w_index;
   logic [TAG_W-1:0]       w_tag;
   logic [IDX_W+OFF_W-1:0] w_hit_idx, w_line_idx;
   logic [RAM_AW-1:0]      w_ram_addr;
   logic                   w_hit, w_last_cyc, w_last_word;
   logic                   w_ram_we, w_fill_we, w_hit_we, w_tag_we;

   assign w_off       = r_addr[OFF_W-1:0];
   assign w_index     = r_addr[OFF_W +: IDX_W];
   assign w_tag       = r_addr[ADDR_WIDTH-1 -: TAG_W];
   assign w_hit_idx   = {w_index, w_off};
   assign w_line_idx  = {w_index, r_word};
   assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_last_cyc  = (r_cnt == CNT_W'(RAM_LATENCY - 1));
   assign w_last_word = (r_word == OFF_W'(LINE_SIZE - 1));

   // Victim write-back uses the stored tag, fill uses the requested tag; RAM aliases mod RAM_WORDS.
   assign w_ram_addr = (r_state == S_WB) ? RAM_AW'({r_tag[w_index], w_index, r_word})
                                         : RAM_AW'({w_tag, w_index, r_word});

   assign bus.ready = r_ready;
   assign bus.dout  = r_dout;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_din   <= '0;
         r_wr    <= 1'b0;
         r_cnt   <= '0;
         r_word  <= '0;
         r_ready <= 1'b1;
         r_dout  <= '0;
         r_valid <= '0;
         r_dirty <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_addr  <= w_addr_nxt;
         r_din   <= w_din_nxt;
         r_wr    <= w_wr_nxt;
         r_cnt   <= w_cnt_nxt;
         r_word  <= w_word_nxt;
         r_ready <= w_ready_nxt;
         r_dout  <= w_dout_nxt;
         if (w_tag_we) begin
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
         end
         if (w_hit_we) r_dirty[w_index] <= 1'b1;
      end
   end

   // Storage arrays carry no reset; enables are idle while reset holds the FSM in S_IDLE.
   always_ff @(posedge clk) begin
      if (w_ram_we)  r_ram[w_ram_addr]   <= r_data[w_line_idx];
      if (w_fill_we) r_data[w_line_idx]  <= r_ram[w_ram_addr];
      if (w_hit_we)  r_data[w_hit_idx]   <= r_din;
      if (w_tag_we)  r_tag[w_index]      <= w_tag;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_din_nxt   = r_din;
      w_wr_nxt    = r_wr;
      w_cnt_nxt   = r_cnt;
      w_word_nxt  = r_word;
      w_ready_nxt = r_ready;
      w_dout_nxt  = r_dout;
      w_ram_we    = 1'b0;
      w_fill_we   = 1'b0;
      w_hit_we    = 1'b0;
      w_tag_we    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.re || bus.we) begin
               w_addr_nxt  = bus.addr;
               w_din_nxt   = bus.din;
               w_wr_nxt    = bus.we;
               w_ready_nxt = 1'b0;
               w_state_nxt = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (w_hit) begin
               if (r_wr) w_hit_we   = 1'b1;
               else      w_dout_nxt = r_data[w_hit_idx];
               w_ready_nxt = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt   = '0;
               w_word_nxt  = '0;
               w_state_nxt = (r_valid[w_index] && r_dirty[w_index]) ? S_WB : S_FILL;
            end
         end
         S_WB: begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (w_last_cyc) begin
               w_ram_we   = 1'b1;
               w_cnt_nxt  = '0;
               w_word_nxt = r_word + OFF_W'(1);
               if (w_last_word) w_state_nxt = S_FILL;
            end
         end
         default: begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (w_last_cyc) begin
               w_fill_we  = 1'b1;
               w_cnt_nxt  = '0;
               w_word_nxt = r_word + OFF_W'(1);
               if (w_last_word) begin
                  w_tag_we    = 1'b1;
                  w_state_nxt = S_LOOKUP;
               end
            end
         end
      endcase
   end
endmodule

// File: tb/tb_cached_memory.sv
// Directed test of cached_memory: hit/miss latencies, write-back eviction, reset abort, request priority.
module tb_cached_memory;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk  = 0;
   int   n_pass = 0;

   localparam logic [63:0] VAL_A = 64'h0123456789abcdef;

   cached_memory_if #(.ADDR_WIDTH(64), .WORD_WIDTH(64)) bus ();

   cached_memory dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   // Issue one request, count ready-low cycles, check latency and dout; optionally spam requests while busy.
   task automatic do_op(input logic w, input logic r, input logic [63:0] a, input logic [63:0] d,
                        input int exp_lat, input logic [63:0] exp_dout, input logic spam,
                        input string tag);
      int k;
      @(negedge clk);
      bus.we = w; bus.re = r; bus.addr = a; bus.din = d;
      @(posedge clk);
      @(negedge clk);
      bus.we = spam; bus.re = 1'b0;
      if (spam) begin bus.addr = 64'd3; bus.din = 64'hdead; end
      chk({tag, "_accept"}, 64'(bus.ready), 64'd0);
      k = 0;
      while (!bus.ready && k < 300) begin
         @(negedge clk);
         k++;
         if (bus.ready) bus.we = 1'b0;
      end
      bus.we = 1'b0;
      chk({tag, "_lat"}, 64'(k), 64'(exp_lat));
      chk({tag, "_dout"}, bus.dout, exp_dout);
   endtask

   initial begin
      bus.re = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.din = '0;
      #22 rst = 1'b1;
      @(negedge clk);
      chk("rst_ready", 64'(bus.ready), 64'd1);
      chk("rst_dout", bus.dout, 64'd0);

      do_op(1, 0, 64'd1,   VAL_A,    52, 64'd0,  0, "w1");
      do_op(0, 1, 64'd1,   64'd0,     1, VAL_A,  0, "r1");
      do_op(1, 0, 64'd257, 64'd123, 102, VAL_A,  0, "w257");
      do_op(0, 1, 64'd257, 64'd0,     1, 64'd123, 0, "r257");
      do_op(0, 1, 64'd1,   64'd0,   102, VAL_A,  0, "r1_evict");
      do_op(1, 0, 64'd256, 64'd321,  52, VAL_A,  0, "w256");
      do_op(0, 1, 64'd257, 64'd0,     1, 64'd123, 0, "r257_b");
      do_op(0, 1, 64'd1,   64'd0,   102, VAL_A,  0, "r1_b");
      do_op(0, 1, 64'd256, 64'd0,    52, 64'd321, 0, "r256_b");
      do_op(1, 0, 64'd1,   64'd5,    52, 64'd321, 0, "w1_5");
      do_op(0, 1, 64'd1,   64'd0,     1, 64'd5,  0, "r1_c");
      do_op(0, 1, 64'd257, 64'd0,   102, 64'd123, 0, "r257_c");
      do_op(0, 1, 64'd256, 64'd0,     1, 64'd321, 0, "r256_c");

      // Asynchronous reset in the middle of a fill
      @(negedge clk);
      bus.re = 1'b1; bus.addr = 64'd1;
      @(posedge clk);
      @(negedge clk);
      bus.re = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_ready", 64'(bus.ready), 64'd1);
      chk("mid_rst_dout", bus.dout, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      do_op(0, 1, 64'd1,   64'd0,       52, 64'd5,  0, "cold_r1");
      do_op(1, 1, 64'd3,   64'h77,      52, 64'd5,  0, "both_w3");
      do_op(0, 1, 64'd3,   64'd0,        1, 64'h77, 0, "r3");
      do_op(1, 0, 64'd259, 64'h99,     102, 64'h77, 1, "w259_spam");
      @(negedge clk);
      chk("spam_ignored", 64'(bus.ready), 64'd1);
      do_op(0, 1, 64'd3,   64'd0,      102, 64'h77, 0, "r3_b");
      do_op(0, 1, 64'd259, 64'd0,       52, 64'h99, 0, "r259");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
